seq_gen_1010: RTL and testbench

Serial pattern transmitter that drives the single-bit input stream of the `1010` sequence detectors, at one bit per `clk`. On a start request it emits a programmable `PAT_W`-bit pattern (default `1010`, MSB first) a requested number of times. It inserts a programmable number of idle-zero cycles between repetitions, then pulses `done`. It sits upstream of the detector as its stimulus source in system-level checks and self-test paths.

---
 rtl/seq_gen_1010_if.sv | 38 +++
 rtl/seq_gen_1010.sv | 173 +++++++++++++++++
 tb/tb_seq_gen_1010.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_gen_1010_if.sv
// seq_gen_1010_if
//   Control/data bundle between a stimulus controller and seq_gen_1010.
//   master : drives start/abort/reps/gap, observes the serial stream and status.
//   slave  : the pattern generator side.
//   Signals:
//     start   - request a run (seen only while the generator is idle)
//     abort   - synchronous cancel of a run in progress
//     reps    - repetition count, CNT_W bits (0 = continuous when looping is built in)
//     gap     - idle-zero cycles between repetitions, GAP_W bits
//     out     - serial pattern bit
//     frame   - out currently carries a pattern bit
//     busy    - a run is in progress (pattern or gap)
//     done    - one-cycle pulse after the final bit of a finite run
//     pat_cnt - fully emitted patterns since the last accepted start (saturating)
interface seq_gen_1010_if #(
   parameter int CNT_W = 8,
   parameter int GAP_W = 4
);
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] reps;
   logic [GAP_W-1:0] gap;
   logic             out;
   logic             frame;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] pat_cnt;

   modport master (
      output start, abort, reps, gap,
      input  out, frame, busy, done, pat_cnt
   );

   modport slave (
      input  start, abort, reps, gap,
      output out, frame, busy, done, pat_cnt
   );
endinterface

// File: rtl/seq_gen_1010.sv
// seq_gen_1010
//   Serial pattern transmitter feeding the 1010 sequence detectors, one bit per
//   clk. On start it shifts PATTERN out MSB first, reps times, with gap
//   idle-zero cycles between repetitions, then pulses done.
//   Ports:
//     clk   - clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - seq_gen_1010_if.slave (start/abort/reps/gap in;
//             out/frame/busy/done/pat_cnt out, all registered)
//   Build option:
//     SEQ_GEN_LOOP_EN - when defined, start with reps=0 runs the pattern
//                       continuously until abort or reset (no done pulse).
//                       When undefined, reps=0 requests are ignored.
module seq_gen_1010 #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
   parameter int               CNT_W   = 8,
   parameter int               GAP_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   seq_gen_1010_if.slave    bus
);

   localparam int               IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d, idx_dec;
   logic [CNT_W-1:0] left_q, left_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [GAP_W-1:0] gcnt_q, gcnt_d;
   logic             loop_q, loop_d;
   logic             out_q, out_d;
   logic             frame_q, frame_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             accept;
   logic             last_rep;

`ifdef SEQ_GEN_LOOP_EN
   assign accept = bus.start;
`else
   assign accept = bus.start && (bus.reps != '0);
`endif

   assign idx_dec  = idx_q - 1'b1;
   assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
   // In continuous mode the remaining count is never consulted.
   assign last_rep = !loop_q && (left_q == CNT_W'(1));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      left_d  = left_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      gcnt_d  = gcnt_q;
      loop_d  = loop_q;
      out_d   = 1'b0;
      frame_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      // Outputs are computed for the state being entered, so that the
      // registered copies line up with the state they describe.
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SEND;
               idx_d   = IDX_TOP;
               left_d  = bus.reps;
               gap_d   = bus.gap;
               loop_d  = (bus.reps == '0);
               cnt_d   = '0;
               out_d   = PATTERN[PAT_W-1];
               frame_d = 1'b1;
               busy_d  = 1'b1;
            end
         end

         SEND: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (idx_q != '0) begin
               idx_d   = idx_dec;
               out_d   = PATTERN[idx_dec];
               frame_d = 1'b1;
               busy_d  = 1'b1;
            end else begin
               cnt_d = cnt_inc;
               if (!loop_q) begin
                  left_d = left_q - 1'b1;
               end
               if (last_rep) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else if (gap_q == '0) begin
                  idx_d   = IDX_TOP;
                  out_d   = PATTERN[PAT_W-1];
                  frame_d = 1'b1;
                  busy_d  = 1'b1;
               end else begin
                  state_d = GAP;
                  gcnt_d  = gap_q;
                  busy_d  = 1'b1;
               end
            end
         end

         GAP: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (gcnt_q == GAP_W'(1)) begin
               state_d = SEND;
               idx_d   = IDX_TOP;
               out_d   = PATTERN[PAT_W-1];
               frame_d = 1'b1;
               busy_d  = 1'b1;
            end else begin
               gcnt_d = gcnt_q - 1'b1;
               busy_d = 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         left_q  <= '0;
         cnt_q   <= '0;
         gap_q   <= '0;
         gcnt_q  <= '0;
         loop_q  <= 1'b0;
         out_q   <= 1'b0;
         frame_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         left_q  <= left_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         gcnt_q  <= gcnt_d;
         loop_q  <= loop_d;
         out_q   <= out_d;
         frame_q <= frame_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.out     = out_q;
   assign bus.frame   = frame_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.pat_cnt = cnt_q;

endmodule

// File: tb/tb_seq_gen_1010.sv
// tb_seq_gen_1010
//   Table of {inputs, expected outputs} vectors plus generated multi-cycle runs.
//   Expected records go into a scoreboard queue as stimulus is driven and are
//   popped and compared one per cycle, #1 after the rising edge.
module tb_seq_gen_1010;

   localparam int         CNT_W = 8;
   localparam int         GAP_W = 4;
   localparam logic [3:0] PAT   = 4'b1010;

   typedef struct {
      logic             out;
      logic             frame;
      logic             busy;
      logic             done;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   typedef struct {
      logic             start;
      logic             abort;
      logic [CNT_W-1:0] reps;
      logic [GAP_W-1:0] gap;
      exp_t             e;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   seq_gen_1010_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

   seq_gen_1010 #(
      .PAT_W  (4),
      .PATTERN(4'b1010),
      .CNT_W  (CNT_W),
      .GAP_W  (GAP_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk_e(input bit o, input bit f, input bit b, input bit d, input int c);
      exp_t e;
      e.out   = o;
      e.frame = f;
      e.busy  = b;
      e.done  = d;
      e.cnt   = CNT_W'(c);
      return e;
   endfunction

   function automatic vec_t mk(input bit s, input bit a, input int r, input int g,
                               input bit o, input bit f, input bit b, input bit d, input int c);
      vec_t v;
      v.start = s;
      v.abort = a;
      v.reps  = CNT_W'(r);
      v.gap   = GAP_W'(g);
      v.e     = mk_e(o, f, b, d, c);
      return v;
   endfunction

   task automatic cmp(input string nm);
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL %s: scoreboard empty", nm);
         return;
      end
      e = sb.pop_front();
      if (bus.out !== e.out || bus.frame !== e.frame || bus.busy !== e.busy ||
          bus.done !== e.done || bus.pat_cnt !== e.cnt) begin
         bad++;
         $display("FAIL %s: got out=%b frame=%b busy=%b done=%b cnt=%0d, want out=%b frame=%b busy=%b done=%b cnt=%0d",
                  nm, bus.out, bus.frame, bus.busy, bus.done, bus.pat_cnt,
                  e.out, e.frame, e.busy, e.done, e.cnt);
      end
   endtask

   task automatic check_int(input string nm, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", nm, got, want);
      end
   endtask

   task automatic step(input logic s, input logic a, input logic [CNT_W-1:0] r, input logic [GAP_W-1:0] g);
      @(negedge clk);
      bus.start = s;
      bus.abort = a;
      bus.reps  = r;
      bus.gap   = g;
      @(posedge clk);
      #1;
   endtask

   // Full finite run: expected stream is the pattern reps times with gap zeros
   // between, then one done cycle, then idle.
   task automatic run_seq(input int reps, input int gap, input string nm);
      logic [3:0] pat_v;
      logic [3:0] hist;
      int         n;
      int         busy_cycles;
      int         hits;
      pat_v = PAT;
      for (int r = 0; r < reps; r++) begin
         for (int b = 3; b >= 0; b--) sb.push_back(mk_e(pat_v[b], 1'b1, 1'b1, 1'b0, r));
         if (r < reps - 1)
            for (int k = 0; k < gap; k++) sb.push_back(mk_e(1'b0, 1'b0, 1'b1, 1'b0, r + 1));
      end
      sb.push_back(mk_e(1'b0, 1'b0, 1'b0, 1'b1, reps));
      sb.push_back(mk_e(1'b0, 1'b0, 1'b0, 1'b0, reps));
      n           = sb.size();
      busy_cycles = 0;
      hits        = 0;
      hist        = '0;
      for (int i = 0; i < n; i++) begin
         step(i == 0, 1'b0, CNT_W'(reps), GAP_W'(gap));
         cmp($sformatf("%s[%0d]", nm, i));
         if (bus.busy === 1'b1) busy_cycles++;
         hist = {hist[2:0], bus.out};
         if (hist == 4'b1010) begin
            hits++;
            hist = '0;
         end
      end
      check_int({nm, "_busy_cycles"}, busy_cycles, reps * 4 + (reps - 1) * gap);
      check_int({nm, "_detector_hits"}, hits, reps);
   endtask

   vec_t tbl[17];

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.reps  = '0;
      bus.gap   = '0;

      // single repetition, then a 3-rep/gap-1 run aborted on the 2nd rep's third bit
      tbl[0]  = mk(1, 0, 1, 0,  1, 1, 1, 0, 0);
      tbl[1]  = mk(0, 0, 1, 0,  0, 1, 1, 0, 0);
      tbl[2]  = mk(0, 0, 1, 0,  1, 1, 1, 0, 0);
      tbl[3]  = mk(0, 0, 1, 0,  0, 1, 1, 0, 0);
      tbl[4]  = mk(0, 0, 1, 0,  0, 0, 0, 1, 1);
      tbl[5]  = mk(0, 0, 1, 0,  0, 0, 0, 0, 1);
      tbl[6]  = mk(1, 0, 3, 1,  1, 1, 1, 0, 0);
      tbl[7]  = mk(1, 0, 5, 0,  0, 1, 1, 0, 0);  // start during SEND ignored
      tbl[8]  = mk(0, 0, 3, 1,  1, 1, 1, 0, 0);
      tbl[9]  = mk(0, 0, 3, 1,  0, 1, 1, 0, 0);
      tbl[10] = mk(0, 0, 3, 1,  0, 0, 1, 0, 1);
      tbl[11] = mk(0, 0, 3, 1,  1, 1, 1, 0, 1);
      tbl[12] = mk(0, 0, 3, 1,  0, 1, 1, 0, 1);
      tbl[13] = mk(0, 0, 3, 1,  1, 1, 1, 0, 1);
      tbl[14] = mk(0, 1, 3, 1,  0, 0, 0, 0, 1);  // abort ends the third bit
      tbl[15] = mk(0, 0, 3, 1,  0, 0, 0, 0, 1);
      tbl[16] = mk(0, 0, 3, 1,  0, 0, 0, 0, 1);

      // asynchronous reset between edges
      #2 rst_n = 1'b0;
      #1;
      sb.push_back(mk_e(0, 0, 0, 0, 0));
      cmp("reset_async");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         sb.push_back(tbl[i].e);
         step(tbl[i].start, tbl[i].abort, tbl[i].reps, tbl[i].gap);
         cmp($sformatf("tbl[%0d]", i));
      end

      run_seq(2, 0, "reps2_gap0");
      run_seq(3, 2, "reps3_gap2");

`ifdef SEQ_GEN_LOOP_EN
      begin
         logic [3:0] pat_v;
         pat_v = PAT;
         for (int j = 0; j < 41; j++) begin
            sb.push_back(mk_e(pat_v[3 - (j % 4)], 1'b1, 1'b1, 1'b0, j / 4));
            step(j == 0, 1'b0, '0, '0);
            cmp($sformatf("loop[%0d]", j));
         end
         sb.push_back(mk_e(0, 0, 0, 0, 10));
         step(1'b0, 1'b1, '0, '0);
         cmp("loop_abort");
         sb.push_back(mk_e(0, 0, 0, 0, 10));
         step(1'b0, 1'b0, '0, '0);
         cmp("loop_after_abort");
      end
`else
      for (int j = 0; j < 4; j++) begin
         sb.push_back(mk_e(0, 0, 0, 0, 3));
         step(1'b1, 1'b0, '0, '0);
         cmp($sformatf("reps0_ignored[%0d]", j));
      end
`endif

      // reset asserted mid-GAP: clears without a clock edge
      for (int b = 3; b >= 0; b--) begin
         logic [3:0] pat_v;
         pat_v = PAT;
         sb.push_back(mk_e(pat_v[b], 1'b1, 1'b1, 1'b0, 0));
         step(b == 3, 1'b0, CNT_W'(3), GAP_W'(2));
         cmp($sformatf("pre_gap[%0d]", 3 - b));
      end
      sb.push_back(mk_e(0, 0, 1, 0, 1));
      step(1'b0, 1'b0, CNT_W'(3), GAP_W'(2));
      cmp("in_gap");
      #2 rst_n = 1'b0;
      #1;
      sb.push_back(mk_e(0, 0, 0, 0, 0));
      cmp("reset_mid_gap");
      @(negedge clk);
      rst_n = 1'b1;

      run_seq(1, 0, "after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
